gnrl_rr_priecdr: RTL and testbench

- Parametrised, registered priority encoder with a rotating search pointer.
- Each cycle it finds the first set bit of a request map, starting at the pointer. The search wraps around the top of the map when WRAP=1.
- The grant is presented with a valid/ack handshake. On ack, the pointer moves to one past the granted index, which gives round-robin selection.
- Used by issue/select and free-list logic that needs wrap-around first-set search over wide maps.

---
 rtl/gnrl_rr_priecdr.sv | 81 ++++++++
 tb/tb_gnrl_rr_priecdr.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gnrl_rr_priecdr.sv
// Registered rotating-pointer first-set encoder with valid/ack. The grant appears 1 cycle after the map is presented.
// A held grant (vld & !ack) stalls the outputs. An ack or a pointer load refreshes them from the current map.
module gnrl_rr_priecdr #(
    parameter int  N    = 128,
    parameter bit  WRAP = 1'b1,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_pecdr_ena,
    input  logic [N-1:0] i_pecdr_map,
    input  logic         i_pecdr_start_vld,
    input  logic [W-1:0] i_pecdr_start,
    input  logic         i_pecdr_ack,
    output logic         o_pecdr_vld,
    output logic [W-1:0] o_pecdr_sel,
    output logic [N-1:0] o_pecdr_onehot,
    output logic [W-1:0] o_pecdr_ptr
);

    logic [W-1:0]   ptr_q;
    logic [W-1:0]   sel_q;
    logic           vld_q;
    logic [N-1:0]   onehot_q;

    logic [W-1:0]   eptr;
    logic [W-1:0]   off;
    logic [W-1:0]   winner;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           match;
    logic           upd;

    // A pointer load beats the ack advance. Without a valid grant, an ack does nothing.
    always_comb begin
        eptr = ptr_q;
        if (i_pecdr_start_vld) begin
            eptr = i_pecdr_start;
        end else if (vld_q && i_pecdr_ack) begin
            eptr = sel_q + W'(1);
        end
    end

    // Rotate the map so that eptr lands at bit 0. Zero-fill of the upper half removes the wrap.
    always_comb begin
        dbl   = WRAP ? {i_pecdr_map, i_pecdr_map} : {{N{1'b0}}, i_pecdr_map};
        rot   = N'(dbl >> eptr);
        match = |rot;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = W'(i);
            end
        end
        winner = eptr + off;
    end

    assign upd = !vld_q || i_pecdr_ack || i_pecdr_start_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            vld_q    <= 1'b0;
            sel_q    <= '0;
            onehot_q <= '0;
        end else begin
            ptr_q <= eptr;
            if (upd) begin
                vld_q    <= i_pecdr_ena && match;
                sel_q    <= match ? winner : eptr;
                onehot_q <= (i_pecdr_ena && match) ? (N'(1) << winner) : '0;
            end
        end
    end

    assign o_pecdr_vld    = vld_q;
    assign o_pecdr_sel    = sel_q;
    assign o_pecdr_onehot = onehot_q;
    assign o_pecdr_ptr    = ptr_q;

endmodule

// File: tb/tb_gnrl_rr_priecdr.sv
// Directed bench for gnrl_rr_priecdr: a WRAP=1 and a WRAP=0 instance share one stimulus stream.
module tb_gnrl_rr_priecdr;

    localparam int N = 128;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic [N-1:0] map;
    logic         start_vld;
    logic [W-1:0] start;
    logic         ack;

    logic         w_vld,    n_vld;
    logic [W-1:0] w_sel,    n_sel;
    logic [N-1:0] w_onehot, n_onehot;
    logic [W-1:0] w_ptr,    n_ptr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gnrl_rr_priecdr #(.N(N), .WRAP(1'b1)) u_wrap (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_pecdr_ena       (ena),
        .i_pecdr_map       (map),
        .i_pecdr_start_vld (start_vld),
        .i_pecdr_start     (start),
        .i_pecdr_ack       (ack),
        .o_pecdr_vld       (w_vld),
        .o_pecdr_sel       (w_sel),
        .o_pecdr_onehot    (w_onehot),
        .o_pecdr_ptr       (w_ptr)
    );

    gnrl_rr_priecdr #(.N(N), .WRAP(1'b0)) u_nowrap (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_pecdr_ena       (ena),
        .i_pecdr_map       (map),
        .i_pecdr_start_vld (start_vld),
        .i_pecdr_start     (start),
        .i_pecdr_ack       (ack),
        .o_pecdr_vld       (n_vld),
        .o_pecdr_sel       (n_sel),
        .o_pecdr_onehot    (n_onehot),
        .o_pecdr_ptr       (n_ptr)
    );

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] one;
        one = '0;
        one[i] = 1'b1;
        return one;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b0;
        map       = '0;
        start_vld = 1'b0;
        start     = '0;
        ack       = 1'b0;
        step();
        step();
        chk("rst_vld",    N'(w_vld),  N'(0));
        chk("rst_sel",    N'(w_sel),  N'(0));
        chk("rst_onehot", w_onehot,   N'(0));
        chk("rst_ptr",    N'(w_ptr),  N'(0));
        rst_n = 1'b1;

        // First grant, then a stall that ignores a map change
        ena = 1'b1;
        map = bit_of(16);
        step();
        chk("t1_vld",    N'(w_vld), N'(1));
        chk("t1_sel",    N'(w_sel), N'(16));
        chk("t1_onehot", w_onehot,  bit_of(16));
        map = bit_of(3);
        step();
        chk("t1_hold_sel", N'(w_sel), N'(16));
        step();
        chk("t1_hold_vld", N'(w_vld), N'(1));
        chk("t1_hold_oh",  w_onehot,  bit_of(16));

        // Round-robin through {5,70,127} with ack held
        start_vld = 1'b1;
        start     = 7'd0;
        map       = bit_of(5) | bit_of(70) | bit_of(127);
        step();
        chk("t2_sel0", N'(w_sel), N'(5));
        chk("t2_ptr0", N'(w_ptr), N'(0));
        start_vld = 1'b0;
        ack       = 1'b1;
        step();
        chk("t2_sel1", N'(w_sel), N'(70));
        chk("t2_ptr1", N'(w_ptr), N'(6));
        step();
        chk("t2_sel2", N'(w_sel), N'(127));
        chk("t2_ptr2", N'(w_ptr), N'(71));
        chk("t2_oh2",  w_onehot,  bit_of(127));
        step();
        chk("t2_sel3", N'(w_sel), N'(5));
        chk("t2_ptr3", N'(w_ptr), N'(0));
        step();
        chk("t2_sel4", N'(w_sel), N'(70));
        chk("t2_ptr4", N'(w_ptr), N'(6));
        chk("t2_vld4", N'(w_vld), N'(1));

        // Pointer load and wrap behaviour, WRAP=1 vs WRAP=0
        ack       = 1'b0;
        start_vld = 1'b1;
        start     = 7'd100;
        map       = bit_of(10) | bit_of(120);
        step();
        chk("t3_w_sel", N'(w_sel), N'(120));
        chk("t3_w_ptr", N'(w_ptr), N'(100));
        chk("t3_n_sel", N'(n_sel), N'(120));
        start_vld = 1'b0;
        ack       = 1'b1;
        step();
        chk("t3_w_wrap_sel", N'(w_sel), N'(10));
        chk("t3_w_wrap_vld", N'(w_vld), N'(1));
        chk("t3_n_nowrap_vld", N'(n_vld), N'(0));
        chk("t3_n_nowrap_sel", N'(n_sel), N'(121));
        ack       = 1'b0;
        start_vld = 1'b1;
        start     = 7'd121;
        step();
        chk("t3_n_ld121_vld", N'(n_vld), N'(0));
        chk("t3_n_ld121_sel", N'(n_sel), N'(121));
        chk("t3_n_ld121_oh",  n_onehot,  N'(0));
        chk("t3_w_ld121_sel", N'(w_sel), N'(10));
        start = 7'd0;
        step();
        chk("t3_n_ld0_vld", N'(n_vld), N'(1));
        chk("t3_n_ld0_sel", N'(n_sel), N'(10));
        start_vld = 1'b0;

        // Empty map, then a single bit, then ena=0
        start_vld = 1'b1;
        start     = 7'd0;
        map       = '0;
        step();
        chk("t4_empty_vld", N'(w_vld), N'(0));
        chk("t4_empty_oh",  w_onehot,  N'(0));
        chk("t4_empty_sel", N'(w_sel), N'(0));
        start_vld = 1'b0;
        map       = bit_of(64);
        step();
        chk("t4_b64_vld", N'(w_vld), N'(1));
        chk("t4_b64_sel", N'(w_sel), N'(64));
        chk("t4_b64_oh",  w_onehot,  bit_of(64));
        ena = 1'b0;
        ack = 1'b1;
        step();
        chk("t4_dis_vld", N'(w_vld), N'(0));
        chk("t4_dis_oh",  w_onehot,  N'(0));
        chk("t4_dis_ptr", N'(w_ptr), N'(65));
        step();
        chk("t4_ack_novld_ptr", N'(w_ptr), N'(65));
        ack = 1'b0;
        ena = 1'b1;

        // Load beats ack, then reset drops a held grant asynchronously
        start_vld = 1'b1;
        start     = 7'd40;
        map       = bit_of(2) | bit_of(40) | bit_of(41);
        step();
        chk("t5_sel40", N'(w_sel), N'(40));
        start_vld = 1'b0;
        map       = bit_of(2) | bit_of(41);
        step();
        chk("t5_hold40", N'(w_sel), N'(40));
        ack       = 1'b1;
        start_vld = 1'b1;
        start     = 7'd2;
        step();
        chk("t5_ld_ptr", N'(w_ptr), N'(2));
        chk("t5_ld_sel", N'(w_sel), N'(2));
        ack       = 1'b0;
        start_vld = 1'b0;
        step();
        chk("t5_hold2_vld", N'(w_vld), N'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_arst_vld", N'(w_vld), N'(0));
        chk("t5_arst_ptr", N'(w_ptr), N'(0));
        chk("t5_arst_oh",  w_onehot,  N'(0));

        // A single bit is re-granted every cycle with ack held
        step();
        rst_n = 1'b1;
        map   = bit_of(0);
        step();
        chk("t6_sel_a", N'(w_sel), N'(0));
        chk("t6_vld_a", N'(w_vld), N'(1));
        ack = 1'b1;
        step();
        chk("t6_sel_b", N'(w_sel), N'(0));
        chk("t6_ptr_b", N'(w_ptr), N'(1));
        chk("t6_n_vld_b", N'(n_vld), N'(0));
        step();
        chk("t6_sel_c", N'(w_sel), N'(0));
        chk("t6_vld_c", N'(w_vld), N'(1));
        ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
